// File: rtl/cpmg_pkg.sv
// Shared types and reset-time parameter defaults for the CPMG pulse sequencer.
package cpmg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StP1,
        StTau,
        StPi,
        StEcho,
        StTail,
        StCw
    } cpmg_state_e;

    localparam int unsigned DefPer    = 15;
    localparam int unsigned DefP1wid  = 30;
    localparam int unsigned DefDel    = 200;
    localparam int unsigned DefP2wid  = 30;
    localparam int unsigned DefPbl    = 50;
    localparam int unsigned DefNpi    = 1;
    localparam logic        DefPu     = 1'b1;
    localparam logic        DefBl     = 1'b1;
    localparam int unsigned PerShift  = 16;

    // Zero-length segments would stall the event chain, so widths never go below one cycle.
    function automatic logic [31:0] clamp_min1(logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/cpmg_sequencer_if.sv
// Host parameter bus plus sequencer outputs for the CPMG pulse sequencer.
interface cpmg_sequencer_if #(
    parameter int unsigned WID_W = 16,
    parameter int unsigned PER_W = 8,
    parameter int unsigned NPI_W = 8,
    parameter int unsigned BL_W  = 8
);
    logic             rxd;
    logic             pu;
    logic [PER_W-1:0] per;
    logic [WID_W-1:0] p1wid;
    logic [WID_W-1:0] del;
    logic [WID_W-1:0] p2wid;
    logic [BL_W-1:0]  p_bl;
    logic [NPI_W-1:0] npi;
    logic             bl;
    logic             sync_on;
    logic             pulse_on;
    logic             inhib;
    logic             overrun;

    modport master (
        output rxd, pu, per, p1wid, del, p2wid, p_bl, npi, bl,
        input  sync_on, pulse_on, inhib, overrun
    );

    modport slave (
        input  rxd, pu, per, p1wid, del, p2wid, p_bl, npi, bl,
        output sync_on, pulse_on, inhib, overrun
    );
endinterface

// File: rtl/load_sync.sv
// Brings the asynchronous rxd level into clk_pll and flags its rising edge for one cycle.
module load_sync (
    input  logic clk_pll,
    input  logic reset,
    input  logic rxd,
    output logic load
);
    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk_pll) begin
        if (!reset) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rxd};
            prev_q <= sync_q[1];
        end
    end

    assign load = sync_q[1] & ~prev_q;
endmodule

// File: rtl/cpmg_sequencer.sv
// CW / Hahn / CPMG pulse sequencer: period counter, segment FSM and registered switch outputs.
module cpmg_sequencer
    import cpmg_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned WID_W     = 16,
    parameter int unsigned PER_W     = 8,
    parameter int unsigned NPI_W     = 8,
    parameter int unsigned BL_W      = 8,
    parameter int unsigned PER_SHIFT = PerShift
) (
    input logic             clk_pll,
    input logic             reset,
    cpmg_sequencer_if.slave bus
);
    logic             load, wrap;
    logic             sh_pu_q, ac_pu_q, sh_bl_q, ac_bl_q;
    logic [PER_W-1:0] sh_per_q, ac_per_q;
    logic [WID_W-1:0] sh_p1_q, ac_p1_q, sh_del_q, ac_del_q, sh_p2_q, ac_p2_q;
    logic [BL_W-1:0]  sh_pbl_q, ac_pbl_q;
    logic [NPI_W-1:0] sh_npi_q, ac_npi_q, k_q, k_d;

    cpmg_state_e      state_q, state_d, st;
    logic [CNT_W-1:0] cnt_q, cnt_nx, per_last, evt_q, evt_d, evt, pi_end_q, pi_end_d;
    logic [CNT_W-1:0] del_c, p2_c, pbl_c, win_mid, win_lo, win_hi;
    logic             in_win;
    logic             sync_q, sync_d, pulse_q, pulse_d, inhib_q, inhib_d, ovr_q, ovr_d;

    load_sync u_load_sync (
        .clk_pll (clk_pll),
        .reset   (reset),
        .rxd     (bus.rxd),
        .load    (load)
    );

    // Shadow follows the host on each rxd edge; active copies shadow only at the period wrap.
    always_ff @(posedge clk_pll) begin
        if (!reset) begin
            sh_pu_q  <= DefPu;             ac_pu_q  <= DefPu;
            sh_bl_q  <= DefBl;             ac_bl_q  <= DefBl;
            sh_per_q <= PER_W'(DefPer);    ac_per_q <= PER_W'(DefPer);
            sh_p1_q  <= WID_W'(DefP1wid);  ac_p1_q  <= WID_W'(DefP1wid);
            sh_del_q <= WID_W'(DefDel);    ac_del_q <= WID_W'(DefDel);
            sh_p2_q  <= WID_W'(DefP2wid);  ac_p2_q  <= WID_W'(DefP2wid);
            sh_pbl_q <= BL_W'(DefPbl);     ac_pbl_q <= BL_W'(DefPbl);
            sh_npi_q <= NPI_W'(DefNpi);    ac_npi_q <= NPI_W'(DefNpi);
        end else begin
            if (load) begin
                sh_pu_q  <= bus.pu;
                sh_bl_q  <= bus.bl;
                sh_per_q <= bus.per;
                sh_p1_q  <= WID_W'(clamp_min1(32'(bus.p1wid)));
                sh_del_q <= WID_W'(clamp_min1(32'(bus.del)));
                sh_p2_q  <= WID_W'(clamp_min1(32'(bus.p2wid)));
                sh_pbl_q <= bus.p_bl;
                sh_npi_q <= bus.npi;
            end
            if (wrap) begin
                ac_pu_q  <= sh_pu_q;
                ac_bl_q  <= sh_bl_q;
                ac_per_q <= sh_per_q;
                ac_p1_q  <= sh_p1_q;
                ac_del_q <= sh_del_q;
                ac_p2_q  <= sh_p2_q;
                ac_pbl_q <= sh_pbl_q;
                ac_npi_q <= sh_npi_q;
            end
        end
    end

    assign per_last = ((CNT_W'(ac_per_q) + CNT_W'(1)) << PER_SHIFT) - CNT_W'(1);
    assign wrap     = (cnt_q == per_last);
    assign cnt_nx   = cnt_q + CNT_W'(1);

    assign del_c   = CNT_W'(ac_del_q);
    assign p2_c    = CNT_W'(ac_p2_q);
    assign pbl_c   = CNT_W'(ac_pbl_q);
    assign win_mid = pi_end_q + del_c;
    assign win_lo  = (pbl_c > del_c) ? pi_end_q : win_mid - pbl_c;
    assign win_hi  = win_mid + pbl_c;
    assign in_win  = (cnt_q >= win_lo) && (cnt_q < win_hi);

    always_comb begin
        // IDLE only ever holds counter 0, where the sequence is launched.
        st  = state_q;
        evt = evt_q;
        if (state_q == StIdle) begin
            st  = (ac_npi_q == '0) ? StCw : StP1;
            evt = CNT_W'(ac_p1_q);
        end
        state_d  = st;
        evt_d    = evt;
        k_d      = k_q;
        pi_end_d = pi_end_q;
        ovr_d    = ovr_q;
        sync_d   = 1'b0;
        pulse_d  = 1'b0;
        inhib_d  = ac_bl_q;
        unique case (st)
            StP1: begin
                sync_d  = 1'b1;
                pulse_d = ac_pu_q;
                if (cnt_nx == evt) begin
                    state_d = StTau;
                    evt_d   = evt + del_c;
                end
            end
            StTau: begin
                sync_d = 1'b1;
                if (cnt_nx == evt) begin
                    state_d = StPi;
                    evt_d   = evt + p2_c;
                end
            end
            StPi: begin
                sync_d  = 1'b1;
                pulse_d = 1'b1;
                if (cnt_nx == evt) begin
                    k_d      = k_q + NPI_W'(1);
                    pi_end_d = evt;
                    if (k_d == ac_npi_q) begin
                        state_d = StTail;
                    end else begin
                        state_d = StEcho;
                        evt_d   = evt + (del_c << 1);
                    end
                end
            end
            StEcho: begin
                sync_d = 1'b1;
                if (in_win) inhib_d = 1'b0;
                if (cnt_nx == evt) begin
                    state_d = StPi;
                    evt_d   = evt + p2_c;
                end
            end
            StTail: begin
                if (in_win) inhib_d = 1'b0;
            end
            StCw: begin
                pulse_d = 1'b1;
                inhib_d = 1'b0;
                sync_d  = (cnt_q < CNT_W'(ac_p1_q));
            end
            default: ;
        endcase
        if (wrap) begin
            state_d = StIdle;
            k_d     = '0;
            if (st inside {StP1, StTau, StPi, StEcho}) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_pll) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            evt_q    <= '0;
            k_q      <= '0;
            pi_end_q <= '0;
            sync_q   <= 1'b0;
            pulse_q  <= 1'b0;
            inhib_q  <= 1'b1;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= wrap ? '0 : cnt_nx;
            evt_q    <= evt_d;
            k_q      <= k_d;
            pi_end_q <= pi_end_d;
            sync_q   <= sync_d;
            pulse_q  <= pulse_d;
            inhib_q  <= inhib_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.sync_on  = sync_q;
    assign bus.pulse_on = pulse_q;
    assign bus.inhib    = inhib_q;
    assign bus.overrun  = ovr_q;
endmodule

// File: tb/tb_cpmg_sequencer.sv
// Cycle-by-cycle check of cpmg_sequencer against an arithmetic model of the pulse timeline.
module tb_cpmg_sequencer;
    localparam int unsigned SH = 10;

    typedef struct {
        bit     pu;
        int     per;
        longint p1, del, p2, pbl;
        int     npi;
        bit     bl;
    } prm_t;

    logic clk_pll = 1'b0;
    logic reset   = 1'b0;
    int   n_err   = 0;
    int   n_chk   = 0;

    prm_t   m_act, m_shd;
    longint m_c;
    bit     m_ovr;
    int     m_ld;

    cpmg_sequencer_if bus ();

    cpmg_sequencer #(.PER_SHIFT(SH)) dut (
        .clk_pll (clk_pll),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_pll = ~clk_pll;

    function automatic prm_t defaults();
        prm_t a;
        a.pu = 1; a.per = 15; a.p1 = 30; a.del = 200; a.p2 = 30; a.pbl = 50; a.npi = 1; a.bl = 1;
        return a;
    endfunction

    function automatic longint max1(longint v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic longint plen(prm_t a);
        return longint'(a.per + 1) * (longint'(1) << SH);
    endfunction

    function automatic longint last_end(prm_t a);
        return a.p1 + a.del + longint'(a.npi - 1) * (a.p2 + 2 * a.del) + a.p2;
    endfunction

    // {sync_on, pulse_on, inhib} for counter value c
    function automatic logic [2:0] outs(longint c, prm_t a);
        logic   sy, po, ih;
        bit     inp, win;
        longint s, e, ws;
        if (a.npi == 0) begin
            sy = (c < a.p1);
            return {sy, 1'b1, 1'b0};
        end
        po = 1'b0; inp = 0; win = 0;
        if (c < a.p1) begin po = a.pu; inp = 1; end
        for (int k = 1; k <= a.npi; k++) begin
            s = a.p1 + a.del + longint'(k - 1) * (a.p2 + 2 * a.del);
            e = s + a.p2;
            if (c >= s && c < e) begin po = 1'b1; inp = 1; end
            ws = (a.pbl > a.del) ? e : e + a.del - a.pbl;
            if (c >= ws && c < e + a.del + a.pbl) win = 1;
        end
        sy = (c < last_end(a));
        ih = (win && !inp) ? 1'b0 : a.bl;
        return {sy, po, ih};
    endfunction

    function automatic prm_t capture();
        prm_t a;
        a.pu = bus.pu; a.per = int'(bus.per); a.bl = bus.bl; a.npi = int'(bus.npi);
        a.p1 = max1(longint'(bus.p1wid)); a.del = max1(longint'(bus.del));
        a.p2 = max1(longint'(bus.p2wid)); a.pbl = longint'(bus.p_bl);
        return a;
    endfunction

    task automatic tick();
        logic [3:0] exp_v, got;
        longint     c_pre, len;
        prm_t       nshd;
        c_pre = m_c;
        if (!reset) begin
            exp_v = 4'b0010;
            m_c = 0; m_act = defaults(); m_shd = defaults(); m_ovr = 0; m_ld = 0;
        end else begin
            len = plen(m_act);
            if (m_c == len - 1 && m_act.npi != 0 && last_end(m_act) >= len) m_ovr = 1;
            exp_v = {outs(m_c, m_act), m_ovr};
            nshd = m_shd;
            if (m_ld != 0) begin
                m_ld--;
                if (m_ld == 0) nshd = capture();
            end
            if (m_c == len - 1) begin
                m_c = 0;
                m_act = m_shd;
            end else begin
                m_c++;
            end
            m_shd = nshd;
        end
        @(posedge clk_pll);
        #1;
        got = {bus.sync_on, bus.pulse_on, bus.inhib, bus.overrun};
        n_chk++;
        assert (got === exp_v) else begin
            n_err++;
            $error("FAIL out c=%0d got=%b exp=%b (sync,pulse,inhib,ovr)", c_pre, got, exp_v);
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic to_cnt(longint t);
        for (int i = 0; i < 40000 && m_c != t; i++) tick();
    endtask

    task automatic next_wrap();
        tick();
        to_cnt(0);
    endtask

    task automatic load_params(bit pu, int per, int p1, int del, int p2, int pbl, int npi, bit bl);
        bus.pu = pu; bus.per = 8'(per); bus.p1wid = 16'(p1); bus.del = 16'(del);
        bus.p2wid = 16'(p2); bus.p_bl = 8'(pbl); bus.npi = 8'(npi); bus.bl = bl;
        bus.rxd = 1'b1;
        m_ld = 3;
        run(4);
        bus.rxd = 1'b0;
        run(4);
    endtask

    task automatic check_bit(string tag, logic got, logic exp_b);
        n_chk++;
        assert (got === exp_b) else begin
            n_err++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp_b);
        end
    endtask

    initial begin
        int p1, del, p2, pbl, npi, per;
        bus.rxd = 1'b0; bus.pu = 1'b0; bus.per = '0; bus.p1wid = '0; bus.del = '0;
        bus.p2wid = '0; bus.p_bl = '0; bus.npi = '0; bus.bl = 1'b0;
        m_act = defaults(); m_shd = defaults(); m_c = 0; m_ovr = 0; m_ld = 0;

        run(3);
        reset = 1'b1;
        run(700);

        // Reference npi=2 train on the short period, then del 200->300 loaded mid-period
        load_params(1, 0, 30, 200, 30, 50, 2, 1);
        to_cnt(0);
        run(300);
        load_params(1, 0, 30, 300, 30, 50, 2, 1);
        next_wrap();
        next_wrap();

        // CW, then a reload whose shadow update lands on the wrap edge
        load_params(0, 0, 100, 200, 30, 50, 0, 1);
        next_wrap();
        to_cnt(plen(m_act) - 3);
        load_params(1, 0, 50, 200, 30, 50, 0, 0);
        next_wrap();
        next_wrap();

        for (int it = 0; it < 6; it++) begin
            run(int'($urandom_range(50, 400)));
            per = int'($urandom_range(0, 1));
            p1  = int'($urandom_range(0, 60));
            del = int'($urandom_range(0, 80));
            p2  = int'($urandom_range(0, 60));
            npi = int'($urandom_range(0, 4));
            pbl = int'($urandom_range(0, int'(max1(del) + max1(p2))));
            if (pbl > 255) pbl = 255;
            load_params(1'($urandom_range(0, 1)), per, p1, del, p2, pbl, npi,
                        1'($urandom_range(0, 1)));
            next_wrap();
        end
        next_wrap();
        check_bit("ovr_before", bus.overrun, 1'b0);

        load_params(1, 0, 30, 40000, 30, 50, 3, 1);
        next_wrap();
        next_wrap();
        run(5);
        check_bit("ovr_set", bus.overrun, 1'b1);
        next_wrap();
        run(2);
        check_bit("ovr_sticky", bus.overrun, 1'b1);

        // Reset mid-sequence inside PI1 of the default train
        reset = 1'b0;
        tick();
        reset = 1'b1;
        to_cnt(240);
        reset = 1'b0;
        tick();
        check_bit("rst_pulse", bus.pulse_on, 1'b0);
        check_bit("rst_inhib", bus.inhib, 1'b1);
        check_bit("rst_sync", bus.sync_on, 1'b0);
        reset = 1'b1;
        run(800);
        check_bit("ovr_clear", bus.overrun, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/cpmg_sequencer.md
# cpmg_sequencer

Parametrised multi-echo pulse sequencer for the spin-echo front end: generates the pulse switch, blocking (inhibit) switch and scope trigger for CW, Hahn-echo, or CPMG trains of up to 2^NPI_W−1 pi pulses per period. It replaces the single-echo pulse generator on the 200 MHz PLL domain and is fed by the host register block through a strobe-qualified parameter bus. Parameter updates are double-buffered and take effect only at a period boundary.

## Interface
- CNT_W, 32, period counter width
- WID_W, 16, width of pulse-width/delay fields (cycles)
- PER_W, 8, period field width (units of 2^16 cycles)
- NPI_W, 8, pi-pulse count width
- BL_W, 8, half-width of echo window (cycles)
- clk_pll  in  1  200 MHz PLL clock
- reset  in  1  synchronous, active-low
- rxd  in  1  asynchronous "parameter bus valid" level from host; rising edge loads shadow regs
- pu  in  1  first (pi/2) pulse enable
- per  in  PER_W  period; length = (per+1)·2^16 cycles
- p1wid  in  WID_W  first pulse width
- del  in  WID_W  tau (p1 end to pi start)
- p2wid  in  WID_W  pi pulse width
- p_bl  in  BL_W  echo window half-width
- npi  in  NPI_W  number of pi pulses; 0 = CW mode
- bl  in  1  blocking enable
- sync_on  out  1  scope/SynthHD trigger
- pulse_on  out  1  pulse switch
- inhib  out  1  blocking switch (1 = blocked)
- overrun  out  1  sticky: sequence exceeded period

## Operation
- rxd passes 2-FF sync + rising-edge detect; on edge, all inputs captured into shadow regs. p1wid, del, p2wid clamped to ≥1 at capture.
- Active regs load from shadow on the cycle counter wraps to 0 (and at reset release); never mid-period.
- Counter: 0..(per+1)·2^16−1, then 0.
- States: IDLE, P1, TAU, PI, ECHO, TAIL, CW.
  - IDLE → P1 (npi≠0) or CW (npi=0) at counter 0.
  - P1 (p1wid cycles, pulse_on=pu) → TAU (del cycles) → PI (p2wid cycles, pulse_on=1, k++) → ECHO (2·del cycles, except last) → PI while k<npi; after last PI → TAIL until wrap.
  - CW: pulse_on=1, inhib=0, sync_on=1 for first p1wid cycles.
- Echo window after pi k ends at cycle E: inhib=0 for [E+del−p_bl, E+del+p_bl), saturated to start ≥E; elsewhere inhib=bl. During pulses inhib=bl.
- sync_on=1 from counter 0 through end of last pi pulse.
- All event times computed in CNT_W; no wrap in arithmetic.
- Overrun: if next event ≥ period length, sequence truncated at wrap, overrun set; cleared only by reset.

## Timing
- Outputs registered: value at cycle n+1 reflects counter value n.
- Reset (reset=0): next edge sync_on=0, pulse_on=0, inhib=1, overrun=0, counter=0, state IDLE; shadow/active = defaults (per 15, p1wid 30, del 200, p2wid 30, p_bl 50, npi 1, pu 1, bl 1). Applies mid-sequence.
- rxd edge to shadow: 3 cycles; shadow to active: next wrap.
- rxd edge coinciding with wrap: active takes previous shadow; new values next period.
- Reference sequence (p1 30, del 200, p2 30, npi 2, p_bl 50), counter values: P1 0–29, PI1 230–259, window 410–509, PI2 660–689, window 840–939, sync_on 0–689.

## Structure
- Package cpmg_pkg: state enum, default constants, clamp function.
- Sub-module load_sync: 2-FF synchroniser + rising-edge detector for rxd.
- Single top FSM + counter + event-time register in cpmg_sequencer.

## Test plan
- Reset defaults, npi=1 → pulse_on 0–29 and 230–259, inhib 0 for 410–509, sync_on 0–259, period 16·65536.
- npi=2 reference sequence → exact counter values above; pulse_on low elsewhere.
- npi=0, p1wid=100 → pulse_on constant 1, inhib 0, sync_on high 100 cycles/period.
- rxd edge mid-period changing del 200→300 → current period unchanged, next uses 300.
- per=0, del=40000, npi=3 → overrun=1, truncation at 65535, restart at 0.
- reset low at cycle 240 (inside PI1) → outputs at reset values next cycle; fresh sequence after release.
